// File: rtl/online_otf_converter_if.sv
// online_otf_converter_if: signed-digit stream in, parallel two's-complement result out
interface online_otf_converter_if #(parameter int N = 8);
    logic       enable;
    logic       start;
    logic [1:0] digit_in;
    logic [N:0] result;
    logic       result_valid;
    logic       busy;
    logic       err;

    modport master (output enable, start, digit_in, input result, result_valid, busy, err);
    modport slave  (input enable, start, digit_in, output result, result_valid, busy, err);
endinterface

// File: rtl/online_otf_converter.sv
// online_otf_converter: skips DELTA warm-up digits, then converts N signed digits on the fly to two's complement
module online_otf_converter #(
    parameter int N     = 8,
    parameter int DELTA = 3
) (
    input logic                   clk,
    input logic                   asyn_reset,
    online_otf_converter_if.slave bus
);
    localparam int CW = $clog2((N > DELTA ? N : DELTA) + 1);

    typedef enum logic [1:0] {IDLE, SKIP, CONV} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_b, cnt_inc;
    logic [N:0]    q_q, q_d, qm_q, qm_d, res_q, res_d;
    logic [N-1:0]  q_b, qm_b;
    logic          valid_q, valid_d, err_q, err_d;
    logic          do_skip, do_conv, plus, minus, illegal;

    // State and datapath registers; everything holds unless the next-state logic says otherwise
    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            qm_q    <= '1;
            res_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next state: a consumed start re-seeds Q/QM/counter and the same digit is processed as digit 1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        qm_d    = qm_q;
        res_d   = res_q;
        valid_d = 1'b0;
        err_d   = err_q;
        q_b     = bus.start ? '0 : q_q[N-1:0];
        qm_b    = bus.start ? '1 : qm_q[N-1:0];
        cnt_b   = bus.start ? '0 : cnt_q;
        cnt_inc = cnt_b + 1'b1;
        plus    = bus.digit_in == 2'b01;
        minus   = bus.digit_in == 2'b11;
        illegal = bus.digit_in == 2'b10;
        do_skip = bus.enable && (bus.start ? DELTA != 0 : state_q == SKIP);
        do_conv = bus.enable && (bus.start ? DELTA == 0 : state_q == CONV);
        if (bus.enable && bus.start) begin
            err_d = 1'b0;
            q_d   = '0;
            qm_d  = '1;
        end
        if (do_skip) begin
            state_d = (cnt_inc == CW'(DELTA)) ? CONV : SKIP;
            cnt_d   = (cnt_inc == CW'(DELTA)) ? '0 : cnt_inc;
        end
        if (do_conv) begin
            q_d   = minus ? {qm_b, 1'b1} : {q_b, plus};
            qm_d  = plus ? {q_b, 1'b0} : {qm_b, ~minus};
            err_d = (bus.start ? 1'b0 : err_q) | illegal;
            if (cnt_inc == CW'(N)) begin
                state_d = IDLE;
                cnt_d   = '0;
                res_d   = q_d;
                valid_d = 1'b1;
            end else begin
                state_d = CONV;
                cnt_d   = cnt_inc;
            end
        end
    end

    assign bus.result       = res_q;
    assign bus.result_valid = valid_q;
    assign bus.busy         = state_q != IDLE;
    assign bus.err          = err_q;
endmodule
